// File: rtl/sram_row_seq.sv
// Sequenced SRAM row selector: accepts a row/burst request and walks each row
// through precharge -> wordline -> recovery with a registered one-hot wordline.
module sram_row_seq #(
  parameter int ADDR_W     = 7,
  parameter int LEN_W      = 4,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2,
  parameter int REC_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [LEN_W-1:0]         req_len,
  input  logic                     abort,
  output logic                     precharge_en,
  output logic [(2**ADDR_W)-1:0]   wl,
  output logic [ADDR_W-1:0]        wl_row,
  output logic                     row_done,
  output logic                     busy
);

  // state  | meaning
  // S_IDLE | waiting for a request, req_ready high
  // S_PRE  | bitline precharge for the current row
  // S_WL   | wordline of the current row driven high
  // S_REC  | recovery; row completes on the last cycle

  localparam int ROWS  = 2**ADDR_W;
  localparam int MAX_A = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int MAX_C = (MAX_A > REC_CYCLES) ? MAX_A : REC_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_WL, S_REC} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_phase;
  logic [CNT_W-1:0]  w_phase_load;
  logic              w_phase_tc;
  logic              w_accept;
  logic              w_row_adv;
  logic              r_abort;
  logic [ADDR_W-1:0] r_row;
  logic [LEN_W-1:0]  r_rem;
  logic [ROWS-1:0]   r_wl;

  assign w_phase_tc = (r_phase == '0);
  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_row_adv  = (r_state == S_REC) && (w_next_state == S_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid) w_next_state = S_PRE;
      S_PRE: begin
        if (abort)           w_next_state = S_IDLE;
        else if (w_phase_tc) w_next_state = S_WL;
      end
      S_WL:   if (abort || w_phase_tc) w_next_state = S_REC;
      S_REC: begin
        if (w_phase_tc) begin
          if (r_abort || abort || (r_rem == '0)) w_next_state = S_IDLE;
          else                                   w_next_state = S_PRE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    precharge_en = (r_state == S_PRE);
    // an abort seen on the final recovery cycle still suppresses the pulse
    row_done     = (r_state == S_REC) && w_phase_tc && !r_abort && !abort;
  end

  always_comb begin
    w_phase_load = '0;
    unique case (w_next_state)
      S_PRE:   w_phase_load = CNT_W'(PRE_CYCLES - 1);
      S_WL:    w_phase_load = CNT_W'(WL_CYCLES - 1);
      S_REC:   w_phase_load = CNT_W'(REC_CYCLES - 1);
      default: w_phase_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_abort <= 1'b0;
      r_row   <= '0;
      r_rem   <= '0;
      r_wl    <= '0;
    end else begin
      if (w_next_state != r_state) r_phase <= w_phase_load;
      else if (!w_phase_tc)        r_phase <= r_phase - 1'b1;

      if (w_next_state == S_IDLE)         r_abort <= 1'b0;
      else if (abort && r_state != S_IDLE) r_abort <= 1'b1;

      if (w_accept) begin
        r_row <= req_addr;
        r_rem <= req_len;
      end else if (w_row_adv) begin
        r_row <= r_row + 1'b1;
        r_rem <= r_rem - 1'b1;
      end

      // decode ahead of the flop so the wordline pins see only register outputs
      if (w_next_state == S_WL) r_wl <= ROWS'(1) << r_row;
      else                      r_wl <= '0;
    end
  end

  assign wl     = r_wl;
  assign wl_row = r_row;

endmodule
